// File: rtl/br_tag_alloc.sv
// rtl/br_tag_alloc.sv - branch tag allocator with per-tag dependency masks and mispredict squash
module br_tag_alloc #(
  parameter int NUM_TAGS = 4,
  parameter int ALLOC_W  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ALLOC_W-1:0]                alloc_req_i,
  output logic [ALLOC_W*NUM_TAGS-1:0]       alloc_tag_o,
  output logic [ALLOC_W*NUM_TAGS-1:0]       alloc_mask_o,
  output logic                              alloc_stall_o,
  output logic [NUM_TAGS-1:0]               br_mask_o,
  input  logic                              resolve_valid_i,
  input  logic [NUM_TAGS-1:0]               resolve_tag_i,
  input  logic                              resolve_mispred_i,
  output logic [NUM_TAGS-1:0]               squash_mask_o,
  output logic [$clog2(NUM_TAGS+1)-1:0]     free_cnt_o
);

  localparam int CNT_W = $clog2(NUM_TAGS+1);

  logic [NUM_TAGS-1:0] out_r;
  logic [NUM_TAGS-1:0] out_n;
  logic [NUM_TAGS-1:0] dep_r [NUM_TAGS];
  logic [NUM_TAGS-1:0] dep_n [NUM_TAGS];

  logic                tag_onehot;
  logic                res_legal;
  logic                res_correct;
  logic                res_mispred;
  logic [NUM_TAGS-1:0] correct_clr;
  logic [CNT_W-1:0]    free_cnt;
  int                  req_cnt;
  logic                stall;
  logic [NUM_TAGS-1:0] avail;
  logic [NUM_TAGS-1:0] granted;
  logic [NUM_TAGS-1:0] pick;

  // Resolves of free tags or malformed tags are ignored entirely.
  assign tag_onehot  = (resolve_tag_i != '0) &&
                       ((resolve_tag_i & (resolve_tag_i - NUM_TAGS'(1))) == '0);
  assign res_legal   = resolve_valid_i && tag_onehot && ((resolve_tag_i & out_r) != '0);
  assign res_mispred = res_legal && resolve_mispred_i;
  assign res_correct = res_legal && !resolve_mispred_i;
  assign correct_clr = res_correct ? resolve_tag_i : '0;

  always_comb begin
    squash_mask_o = '0;
    if (res_mispred) begin
      squash_mask_o = resolve_tag_i;
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (out_r[t] && ((dep_r[t] & resolve_tag_i) != '0)) squash_mask_o[t] = 1'b1;
      end
    end
  end

  always_comb begin
    free_cnt = CNT_W'(NUM_TAGS);
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (out_r[i]) free_cnt = free_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    req_cnt = 0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_req_i[k]) req_cnt = req_cnt + 1;
    end
  end

  // Slots take the lowest remaining free tag in order; younger slots see older grants in their mask.
  always_comb begin
    alloc_tag_o  = '0;
    alloc_mask_o = '0;
    stall        = 1'b0;
    avail        = ~out_r;
    granted      = '0;
    pick         = '0;
    if (!res_mispred) begin
      stall = req_cnt > int'(free_cnt);
      if (!stall) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (alloc_req_i[k]) begin
            pick = avail & (~avail + NUM_TAGS'(1));
            alloc_tag_o[k*NUM_TAGS +: NUM_TAGS]  = pick;
            alloc_mask_o[k*NUM_TAGS +: NUM_TAGS] = (out_r & ~correct_clr) | granted;
            granted = granted | pick;
            avail   = avail & ~pick;
          end
        end
      end
    end
  end

  assign alloc_stall_o = stall;

  always_comb begin
    out_n = out_r & ~correct_clr;
    if (res_mispred) out_n = out_n & ~squash_mask_o;
    for (int t = 0; t < NUM_TAGS; t++) dep_n[t] = dep_r[t] & ~correct_clr;
    for (int k = 0; k < ALLOC_W; k++) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (alloc_tag_o[k*NUM_TAGS + t]) begin
          out_n[t] = 1'b1;
          dep_n[t] = alloc_mask_o[k*NUM_TAGS +: NUM_TAGS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= '0;
      for (int t = 0; t < NUM_TAGS; t++) dep_r[t] <= '0;
    end else begin
      out_r <= out_n;
      for (int t = 0; t < NUM_TAGS; t++) dep_r[t] <= dep_n[t];
    end
  end

  assign br_mask_o  = out_r;
  assign free_cnt_o = free_cnt;

endmodule

// File: tb/tb_br_tag_alloc.sv
// tb/tb_br_tag_alloc.sv - directed bench for br_tag_alloc against a set-based reference model
module tb_br_tag_alloc;
  localparam int NT = 4;
  localparam int AW = 2;
  localparam int CW = $clog2(NT+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [AW-1:0]     alloc_req_i = '0;
  logic [AW*NT-1:0]  alloc_tag_o;
  logic [AW*NT-1:0]  alloc_mask_o;
  logic              alloc_stall_o;
  logic [NT-1:0]     br_mask_o;
  logic              resolve_valid_i = 1'b0;
  logic [NT-1:0]     resolve_tag_i = '0;
  logic              resolve_mispred_i = 1'b0;
  logic [NT-1:0]     squash_mask_o;
  logic [CW-1:0]     free_cnt_o;

  int checks = 0;
  int errors = 0;

  br_tag_alloc #(.NUM_TAGS(NT), .ALLOC_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_tag_o(alloc_tag_o), .alloc_mask_o(alloc_mask_o),
    .alloc_stall_o(alloc_stall_o), .br_mask_o(br_mask_o),
    .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
    .resolve_mispred_i(resolve_mispred_i), .squash_mask_o(squash_mask_o),
    .free_cnt_o(free_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference state: which tags are in flight, and which tags each one was speculated under.
  bit m_out [NT];
  bit m_dep [NT][NT];

  logic [AW*NT-1:0] e_tag, e_mask;
  logic             e_stall;
  logic [NT-1:0]    e_squash, e_br;
  int               e_free, e_r;
  bit               e_legal, e_mis, e_correct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    int ones;
    int nreq;
    int freeq[$];
    int gl[$];
    int t;
    ones = 0; e_r = -1; nreq = 0;
    for (int i = 0; i < NT; i++) if (resolve_tag_i[i]) begin ones++; e_r = i; end
    e_legal = 1'b0;
    if (resolve_valid_i && ones == 1) e_legal = m_out[e_r];
    e_mis     = e_legal && resolve_mispred_i;
    e_correct = e_legal && !resolve_mispred_i;
    e_squash = '0;
    if (e_mis) begin
      e_squash[e_r] = 1'b1;
      for (int i = 0; i < NT; i++) if (m_out[i] && m_dep[i][e_r]) e_squash[i] = 1'b1;
    end
    e_br = '0;
    for (int i = 0; i < NT; i++) begin
      e_br[i] = m_out[i];
      if (!m_out[i]) freeq.push_back(i);
    end
    e_free = freeq.size();
    for (int k = 0; k < AW; k++) if (alloc_req_i[k]) nreq++;
    e_stall = !e_mis && (nreq > e_free);
    e_tag = '0; e_mask = '0;
    if (!e_mis && !e_stall) begin
      for (int k = 0; k < AW; k++) begin
        if (alloc_req_i[k]) begin
          t = freeq.pop_front();
          e_tag[k*NT + t] = 1'b1;
          for (int i = 0; i < NT; i++)
            if (m_out[i] && !(e_correct && i == e_r)) e_mask[k*NT + i] = 1'b1;
          foreach (gl[g]) e_mask[k*NT + gl[g]] = 1'b1;
          gl.push_back(t);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_eval();
    if (rst) begin
      for (int i = 0; i < NT; i++) begin
        m_out[i] = 1'b0;
        for (int j = 0; j < NT; j++) m_dep[i][j] = 1'b0;
      end
    end else begin
      if (e_correct) begin
        m_out[e_r] = 1'b0;
        for (int i = 0; i < NT; i++) m_dep[i][e_r] = 1'b0;
      end
      if (e_mis) for (int i = 0; i < NT; i++) if (e_squash[i]) m_out[i] = 1'b0;
      for (int k = 0; k < AW; k++)
        for (int i = 0; i < NT; i++)
          if (e_tag[k*NT + i]) begin
            m_out[i] = 1'b1;
            for (int j = 0; j < NT; j++) m_dep[i][j] = e_mask[k*NT + j];
          end
    end
  end

  always @(negedge clk) begin
    model_eval();
    if (resolve_valid_i && !e_legal)
      $display("note: protocol error, resolve of tag %b ignored at %0t", resolve_tag_i, $time);
    chk("cyc_alloc_tag",  32'(alloc_tag_o),   32'(e_tag));
    chk("cyc_alloc_mask", 32'(alloc_mask_o),  32'(e_mask));
    chk("cyc_stall",      32'(alloc_stall_o), 32'(e_stall));
    chk("cyc_squash",     32'(squash_mask_o), 32'(e_squash));
    chk("cyc_br_mask",    32'(br_mask_o),     32'(e_br));
    chk("cyc_free_cnt",   32'(free_cnt_o),    32'(e_free));
  end

  task automatic drive(input logic r, input logic [AW-1:0] req, input logic rv,
                       input logic [NT-1:0] rtag, input logic mis);
    @(posedge clk);
    #1;
    rst = r; alloc_req_i = req; resolve_valid_i = rv;
    resolve_tag_i = rtag; resolve_mispred_i = mis;
    #2;
  endtask

  initial begin
    drive(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0);
    chk("rst_br_mask", 32'(br_mask_o), 32'h0);
    chk("rst_free",    32'(free_cnt_o), 32'd4);
    chk("rst_stall",   32'(alloc_stall_o), 32'd0);

    drive(1'b0, 2'b11, 1'b0, 4'b0000, 1'b0);
    chk("a2_tag",  32'(alloc_tag_o),  32'b0010_0001);
    chk("a2_mask", 32'(alloc_mask_o), 32'b0001_0000);

    drive(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0);
    chk("a2_br_mask", 32'(br_mask_o),  32'b0011);
    chk("a2_free",    32'(free_cnt_o), 32'd2);
    chk("a3_tag",  32'(alloc_tag_o),  32'b0000_0100);
    chk("a3_mask", 32'(alloc_mask_o), 32'b0000_0011);

    drive(1'b0, 2'b11, 1'b0, 4'b0000, 1'b0);
    chk("over_stall", 32'(alloc_stall_o), 32'd1);
    chk("over_tag",   32'(alloc_tag_o),   32'h0);

    drive(1'b0, 2'b10, 1'b0, 4'b0000, 1'b0);
    chk("over_br_mask", 32'(br_mask_o),   32'b0111);
    chk("slot1_tag",    32'(alloc_tag_o),  32'b1000_0000);
    chk("slot1_mask",   32'(alloc_mask_o), 32'b0111_0000);

    drive(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0);
    chk("full_free",  32'(free_cnt_o),    32'd0);
    chk("full_stall", 32'(alloc_stall_o), 32'd1);

    drive(1'b0, 2'b00, 1'b1, 4'b1000, 1'b0);
    chk("ok_squash", 32'(squash_mask_o), 32'h0);

    drive(1'b0, 2'b11, 1'b1, 4'b0010, 1'b1);
    chk("mp_pre_br", 32'(br_mask_o),     32'b0111);
    chk("mp_squash", 32'(squash_mask_o), 32'b0110);
    chk("mp_tag",    32'(alloc_tag_o),   32'h0);
    chk("mp_stall",  32'(alloc_stall_o), 32'd0);

    drive(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0);
    chk("mp_br_mask", 32'(br_mask_o),  32'b0001);
    chk("mp_free",    32'(free_cnt_o), 32'd3);
    chk("b_tag",  32'(alloc_tag_o),  32'b0000_0010);
    chk("b_mask", 32'(alloc_mask_o), 32'b0000_0001);

    drive(1'b0, 2'b01, 1'b1, 4'b0001, 1'b0);
    chk("rc_tag",  32'(alloc_tag_o),  32'b0000_0100);
    chk("rc_mask", 32'(alloc_mask_o), 32'b0000_0010);

    drive(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0);
    chk("rc_br_mask", 32'(br_mask_o),   32'b0110);
    chk("re_tag",     32'(alloc_tag_o),  32'b0000_0001);
    chk("re_mask",    32'(alloc_mask_o), 32'b0000_0110);

    // 0010 must have lost its dependency on 0001, so only 0001 goes.
    drive(1'b0, 2'b00, 1'b1, 4'b0001, 1'b1);
    chk("dep_clr_squash", 32'(squash_mask_o), 32'b0001);

    drive(1'b0, 2'b00, 1'b1, 4'b0001, 1'b1);
    chk("dep_clr_br",   32'(br_mask_o),     32'b0110);
    chk("stale_squash", 32'(squash_mask_o), 32'h0);

    drive(1'b0, 2'b00, 1'b1, 4'b0110, 1'b1);
    chk("nonhot_squash", 32'(squash_mask_o), 32'h0);

    drive(1'b0, 2'b01, 1'b0, 4'b0000, 1'b0);
    chk("ignored_br", 32'(br_mask_o), 32'b0110);

    drive(1'b1, 2'b11, 1'b1, 4'b0010, 1'b1);
    chk("pre_rst_free", 32'(free_cnt_o), 32'd1);

    drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0);
    chk("mid_rst_br",   32'(br_mask_o),  32'h0);
    chk("mid_rst_free", 32'(free_cnt_o), 32'd4);

    drive(1'b0, 2'b11, 1'b0, 4'b0000, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/br_tag_alloc.md
BR_TAG_ALLOC -- requirements
Module: br_tag_alloc

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 4: number of branch tags, i.e. the maximum number of unresolved speculative branches.
REQ-002 SHALL have parameter ALLOC_W, default 2: branch allocation ports per cycle, slot 0 oldest.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alloc_req_i  input  ALLOC_W  per-slot request for a speculative branch tag.
REQ-006 SHALL have port alloc_tag_o  output  ALLOC_W*NUM_TAGS  per-slot one-hot granted tag, zero if not granted.
REQ-007 SHALL have port alloc_mask_o  output  ALLOC_W*NUM_TAGS  per-slot dependency mask: the older unresolved tags the granted branch is speculative under.
REQ-008 SHALL have port alloc_stall_o  output  1  requested slots cannot all be granted this cycle.
REQ-009 SHALL have port br_mask_o  output  NUM_TAGS  registered mask of outstanding (unresolved) tags.
REQ-010 SHALL have port resolve_valid_i  input  1  a branch resolves this cycle.
REQ-011 SHALL have port resolve_tag_i  input  NUM_TAGS  one-hot tag of the resolving branch.
REQ-012 SHALL have port resolve_mispred_i  input  1  the resolving branch was mispredicted.
REQ-013 SHALL have port squash_mask_o  output  NUM_TAGS  tags to squash this cycle (combinational), zero unless mispredicting.
REQ-014 SHALL have port free_cnt_o  output  $clog2(NUM_TAGS+1)  registered count of free tags.

Function
REQ-015 State SHALL be: outstanding mask out_r[NUM_TAGS], plus a dependency mask dep_r[t][NUM_TAGS] for each tag t; a tag is free iff its out_r bit is 0.
REQ-016 Granted slots SHALL receive distinct free tags in ascending index order: lowest-numbered requesting slot gets the lowest free index; non-requesting slots consume no tag.
REQ-017 Allocation SHALL be all-or-nothing: popcount(alloc_req_i) > free_cnt_o -> no slot granted, alloc_stall_o=1; otherwise all requesting slots granted, alloc_stall_o=0.
REQ-018 Free tags SHALL be computed from registered out_r only; a tag freed by a resolve becomes allocatable the following cycle.
REQ-019 alloc_mask_o of slot k SHALL equal (out_r with the bit of a same-cycle correctly-resolved tag cleared) OR the tags granted to requesting slots < k; it is written into dep_r of the granted tag.
REQ-020 Correct resolve (resolve_valid_i=1, resolve_mispred_i=0): next cycle the tag's out_r bit SHALL be 0 and that bit SHALL be cleared in every dep_r entry; grants in the same cycle proceed normally.
REQ-021 Mispredict (resolve_valid_i=1, resolve_mispred_i=1): squash_mask_o SHALL be resolve_tag_i OR every outstanding tag t whose dep_r[t] contains the resolving tag; out_r SHALL clear all squash_mask_o bits next cycle.
REQ-022 In a mispredict cycle, all allocation requests SHALL be dropped (alloc_tag_o=0, alloc_mask_o=0, alloc_stall_o=0), since the requesting branches are younger and squashed.
REQ-023 Resolve of a tag not in out_r, or a non-one-hot resolve_tag_i, SHALL leave state unchanged and make squash_mask_o=0; the bench flags it as a protocol error.
REQ-024 free_cnt_o SHALL equal NUM_TAGS - popcount(out_r); br_mask_o SHALL equal out_r.
REQ-025 All-tags-outstanding SHALL stall any request; the count SHALL never wrap: no over-allocation, no double-free.

Reset
REQ-026 rst=1 at a rising edge SHALL set out_r=0, all dep_r=0; free_cnt_o=NUM_TAGS, br_mask_o=0, alloc_stall_o=0 when no request.
REQ-027 Reset SHALL override simultaneous allocation and resolve, including mid-operation with tags outstanding.

Verification (NUM_TAGS=4, ALLOC_W=2)
REQ-028 After reset, alloc_req_i=2'b11 -> alloc_tag_o slot0=0001, slot1=0010; alloc_mask slot0=0000, slot1=0001; next cycle br_mask_o=0011, free_cnt_o=2.
REQ-029 Tags 0001,0010,0100 outstanding, alloc_req_i=2'b11 -> alloc_stall_o=1, no grant, br_mask_o unchanged; alloc_req_i=2'b10 -> slot1 granted 1000, slot0 gets 0.
REQ-030 Chain 0001->0010->0100 (each dependent on older), mispredict resolve 0010 -> squash_mask_o=0110; next cycle br_mask_o=0001, free_cnt_o=3.
REQ-031 Tags 0001,0010 outstanding, same cycle correct resolve 0001 and alloc_req_i=2'b01 -> grant 0100, alloc_mask=0010; next cycle br_mask_o=0110, dep of 0010 no longer contains 0001.
REQ-032 Mispredict resolve with alloc_req_i=2'b11 in the same cycle -> no grants, alloc_stall_o=0; assert rst with 3 tags outstanding -> next cycle br_mask_o=0000, free_cnt_o=4.
